cont_updown_mod: RTL and testbench

//  Parametrised up/down modulo counter with synchronous load, wrap or saturate mode,

---
 rtl/cont_pkg.sv | 15 +
 rtl/cont_next.sv | 58 +++++
 rtl/cont_updown_mod.sv | 79 +++++++
 tb/tb_cont_updown_mod.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/cont_pkg.sv
// Shared constants and helpers for the up/down modulo counter.
//   MODE_WRAP / MODE_SAT : values for the SATURATE parameter
//   clamp_load()         : limits a load value to the terminal value
package cont_pkg;

   localparam int unsigned MODE_WRAP = 0;
   localparam int unsigned MODE_SAT  = 1;

   // Operates on 32-bit values so it serves every counter width up to 32.
   function automatic logic [31:0] clamp_load(input logic [31:0] load_val,
                                              input logic [31:0] max_val);
      return (load_val > max_val) ? max_val : load_val;
   endfunction

endpackage

// File: rtl/cont_next.sv
// Combinational next-value and boundary-event logic for cont_updown_mod.
// Ports:
//   cont   in   WIDTH  current counter value
//   up_dn  in   1      1 = count up, 0 = count down
//   enable in   1      count enable
//   loact  in   1      load activate (takes priority over enable)
//   load   in   WIDTH  load value, clamped to MAX_VAL
//   nxt    out  WIDTH  counter value for the next edge
//   evt    out  1      boundary event on the next edge
module cont_next
   import cont_pkg::*;
#(
   parameter int unsigned WIDTH    = 12,
   parameter int unsigned MAX_VAL  = 4095,
   parameter int unsigned SATURATE = MODE_WRAP
) (
   input  logic [WIDTH-1:0] cont,
   input  logic             up_dn,
   input  logic             enable,
   input  logic             loact,
   input  logic [WIDTH-1:0] load,
   output logic [WIDTH-1:0] nxt,
   output logic             evt
);

   localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX_VAL);

   logic at_top;
   logic at_bot;

   assign at_top = (cont == MaxV);
   assign at_bot = (cont == '0);

   always_comb begin
      nxt = cont;
      evt = 1'b0;
      if (loact) begin
         nxt = WIDTH'(clamp_load(32'(load), 32'(MAX_VAL)));
      end else if (enable) begin
         if (up_dn) begin
            if (at_top) begin
               evt = 1'b1;
               nxt = (SATURATE == MODE_SAT) ? cont : '0;
            end else begin
               nxt = cont + 1'b1;
            end
         end else begin
            if (at_bot) begin
               evt = 1'b1;
               nxt = (SATURATE == MODE_SAT) ? cont : MaxV;
            end else begin
               nxt = cont - 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/cont_updown_mod.sv
// Parametrised up/down modulo counter with synchronous load, wrap or saturate
// mode, registered terminal-count pulse, sticky overflow flag and compare match.
// Ports:
//   clk     in   1      clock
//   reset   in   1      synchronous active-high reset
//   enable  in   1      count enable
//   up_dn   in   1      1 = up, 0 = down
//   loact   in   1      load activate
//   load    in   WIDTH  load value
//   cmp     in   WIDTH  compare value
//   ovf_clr in   1      clear sticky overflow flag
//   cont    out  WIDTH  counter value (registered)
//   tc      out  1      terminal-count pulse (registered)
//   ovf     out  1      sticky boundary-event flag (registered)
//   match   out  1      cont == cmp (combinational)
module cont_updown_mod
   import cont_pkg::*;
#(
   parameter int unsigned WIDTH    = 12,
   parameter int unsigned MAX_VAL  = 4095,
   parameter int unsigned SATURATE = MODE_WRAP
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             up_dn,
   input  logic             loact,
   input  logic [WIDTH-1:0] load,
   input  logic [WIDTH-1:0] cmp,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] cont,
   output logic             tc,
   output logic             ovf,
   output logic             match
);

   logic [WIDTH-1:0] cont_q;
   logic [WIDTH-1:0] cont_d;
   logic             tc_q;
   logic             ovf_q;
   logic             evt;

   cont_next #(
      .WIDTH    (WIDTH),
      .MAX_VAL  (MAX_VAL),
      .SATURATE (SATURATE)
   ) u_next (
      .cont   (cont_q),
      .up_dn  (up_dn),
      .enable (enable),
      .loact  (loact),
      .load   (load),
      .nxt    (cont_d),
      .evt    (evt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         cont_q <= '0;
         tc_q   <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         cont_q <= cont_d;
         tc_q   <= evt;
         // A boundary event on the same edge beats the clear.
         if (evt) begin
            ovf_q <= 1'b1;
         end else if (ovf_clr) begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign cont  = cont_q;
   assign tc    = tc_q;
   assign ovf   = ovf_q;
   assign match = (cont_q == cmp);

endmodule

// File: tb/tb_cont_updown_mod.sv
// Three counter configurations share one stimulus bus; each vector names the
// instance whose outputs it checks: 0 = 12-bit/4095 wrap, 1 = 4-bit/9 wrap,
// 2 = 4-bit/9 saturate. Every test section starts with a reset.
module tb_cont_updown_mod;

   typedef struct {
      int          d;
      logic        rst, en, up, ld, clr;
      logic [11:0] ldv, cmpv;
      logic [11:0] e_cont;
      logic        e_tc, e_ovf, e_match;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0, enable = 1'b0, up_dn = 1'b0, loact = 1'b0, ovf_clr = 1'b0;
   logic [11:0] load = '0, cmp = '0;

   logic [11:0] cont_a;
   logic [3:0]  cont_b, cont_c;
   logic        tc_a, tc_b, tc_c, ovf_a, ovf_b, ovf_c, match_a, match_b, match_c;

   int checks = 0;
   int errors = 0;

   vec_t vecs[$];
   vec_t exp_q[$];

   always #5 clk = ~clk;

   cont_updown_mod #(.WIDTH(12), .MAX_VAL(4095), .SATURATE(0)) dut_a (
      .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .loact(loact),
      .load(load), .cmp(cmp), .ovf_clr(ovf_clr),
      .cont(cont_a), .tc(tc_a), .ovf(ovf_a), .match(match_a)
   );

   cont_updown_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) dut_b (
      .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .loact(loact),
      .load(load[3:0]), .cmp(cmp[3:0]), .ovf_clr(ovf_clr),
      .cont(cont_b), .tc(tc_b), .ovf(ovf_b), .match(match_b)
   );

   cont_updown_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) dut_c (
      .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .loact(loact),
      .load(load[3:0]), .cmp(cmp[3:0]), .ovf_clr(ovf_clr),
      .cont(cont_c), .tc(tc_c), .ovf(ovf_c), .match(match_c)
   );

   function automatic vec_t v(input int d, input int rst, input int en, input int up,
                              input int ld, input int ldv, input int cmpv, input int clr,
                              input int ec, input int etc, input int eovf, input int em);
      vec_t s;
      s.d       = d;
      s.rst     = (rst != 0);
      s.en      = (en != 0);
      s.up      = (up != 0);
      s.ld      = (ld != 0);
      s.clr     = (clr != 0);
      s.ldv     = 12'(ldv);
      s.cmpv    = 12'(cmpv);
      s.e_cont  = 12'(ec);
      s.e_tc    = (etc != 0);
      s.e_ovf   = (eovf != 0);
      s.e_match = (em != 0);
      return s;
   endfunction

   task automatic check(input string name, input int idx, input logic [11:0] act,
                        input logic [11:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s vec %0d: got %0d, expected %0d", name, idx, act, req);
      end
   endtask

   // Drive one vector before the edge, queue its expectation, compare after the edge.
   task automatic apply(input vec_t s, input int idx);
      vec_t e;
      logic [11:0] a_cont;
      logic        a_tc, a_ovf, a_match;
      @(negedge clk);
      reset   = s.rst;
      enable  = s.en;
      up_dn   = s.up;
      loact   = s.ld;
      load    = s.ldv;
      cmp     = s.cmpv;
      ovf_clr = s.clr;
      exp_q.push_back(s);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      case (e.d)
         0:       begin a_cont = cont_a;        a_tc = tc_a; a_ovf = ovf_a; a_match = match_a; end
         1:       begin a_cont = {8'd0, cont_b}; a_tc = tc_b; a_ovf = ovf_b; a_match = match_b; end
         default: begin a_cont = {8'd0, cont_c}; a_tc = tc_c; a_ovf = ovf_c; a_match = match_c; end
      endcase
      check($sformatf("cont[d%0d]", e.d), idx, a_cont, e.e_cont);
      check($sformatf("tc[d%0d]", e.d), idx, 12'(a_tc), 12'(e.e_tc));
      check($sformatf("ovf[d%0d]", e.d), idx, 12'(a_ovf), 12'(e.e_ovf));
      check($sformatf("match[d%0d]", e.d), idx, 12'(a_match), 12'(e.e_match));
   endtask

   initial begin
      // 12-bit: count up 5 from reset
      vecs.push_back(v(0, 1,0,0, 0,0, 5,0,  0,0,0,0));
      for (int i = 1; i <= 5; i++) vecs.push_back(v(0, 0,1,1, 0,0, 5,0, i,0,0, (i == 5)));
      // 4-bit wrap: load 8, up to 9 then wrap; sticky ovf; clear; direction switch; clamp
      vecs.push_back(v(1, 1,0,0, 0,0, 9,0,  0,0,0,0));
      vecs.push_back(v(1, 0,0,0, 1,8, 9,0,  8,0,0,0));
      vecs.push_back(v(1, 0,1,1, 0,0, 9,0,  9,0,0,1));
      vecs.push_back(v(1, 0,1,1, 0,0, 9,0,  0,1,1,0));
      vecs.push_back(v(1, 0,0,0, 0,0, 9,0,  0,0,1,0));
      vecs.push_back(v(1, 0,0,0, 0,0, 9,1,  0,0,0,0));
      vecs.push_back(v(1, 0,0,0, 1,3, 9,0,  3,0,0,0));
      vecs.push_back(v(1, 0,1,1, 0,0, 9,0,  4,0,0,0));
      vecs.push_back(v(1, 0,1,0, 0,0, 9,0,  3,0,0,0));
      vecs.push_back(v(1, 0,0,0, 1,10,9,0,  9,0,0,1));
      // 4-bit saturate: down into 0, repeated tc; clamp load; saturate at top
      vecs.push_back(v(2, 1,0,0, 0,0, 9,0,  0,0,0,0));
      vecs.push_back(v(2, 0,0,0, 1,1, 9,0,  1,0,0,0));
      vecs.push_back(v(2, 0,1,0, 0,0, 9,0,  0,0,0,0));
      vecs.push_back(v(2, 0,1,0, 0,0, 9,0,  0,1,1,0));
      vecs.push_back(v(2, 0,1,0, 0,0, 9,0,  0,1,1,0));
      vecs.push_back(v(2, 0,0,0, 1,15,9,0,  9,0,1,1));
      vecs.push_back(v(2, 0,1,1, 0,0, 9,0,  9,1,1,1));
      vecs.push_back(v(2, 0,1,1, 0,0, 9,1,  9,1,1,1));
      vecs.push_back(v(2, 0,0,0, 0,0, 9,0,  9,0,1,1));
      vecs.push_back(v(2, 0,0,0, 0,0, 9,1,  9,0,0,1));
      // Priorities: load over enable, reset over load, event over ovf_clr
      vecs.push_back(v(1, 1,0,0, 0,0, 0,0,  0,0,0,1));
      vecs.push_back(v(1, 0,1,1, 1,7, 0,0,  7,0,0,0));
      vecs.push_back(v(1, 1,1,1, 1,5, 0,0,  0,0,0,1));
      vecs.push_back(v(1, 0,1,0, 0,0, 0,0,  9,1,1,0));
      vecs.push_back(v(1, 0,1,1, 0,0, 0,1,  0,1,1,1));
      vecs.push_back(v(1, 0,0,0, 0,0, 0,1,  0,0,0,1));
      // 12-bit: wrap down from 0, then reset mid-count clears everything
      vecs.push_back(v(0, 1,0,0, 0,0, 4095,0,    0,0,0,0));
      vecs.push_back(v(0, 0,1,0, 0,0, 4095,0, 4095,1,1,1));
      vecs.push_back(v(0, 0,0,0, 1,99,4095,0,   99,0,1,0));
      vecs.push_back(v(0, 0,1,1, 0,0, 4095,0,  100,0,1,0));
      vecs.push_back(v(0, 1,1,1, 0,0, 4095,0,    0,0,0,0));

      foreach (vecs[i]) apply(vecs[i], i);

      // Hand sequence: count to 3, then hold for 10 cycles with enable low
      apply(v(0, 1,0,0, 0,0, 3,0, 0,0,0,0), 100);
      for (int i = 1; i <= 3; i++) apply(v(0, 0,1,1, 0,0, 3,0, i,0,0, (i == 3)), 100 + i);
      for (int i = 0; i < 10; i++) apply(v(0, 0,0,1, 0,0, 3,0, 3,0,0,1), 110 + i);

      // match follows cmp combinationally with no clock edge
      #2;
      cmp = 12'd4;
      #1;
      check("match_comb", 200, 12'(match_a), 12'd0);
      cmp = 12'd3;
      #1;
      check("match_comb", 201, 12'(match_a), 12'd1);

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
